// File: rtl/lc4_div_seq.sv
// lc4_div_seq: 16-bit unsigned restoring divider (DIV/MOD) retiring one quotient bit per clock.
// Build option: define LC4_DIV_ZERO_FAST_EN to complete a divide-by-zero at the accepting edge.

module cla16 (
   input  logic [15:0] a_i,
   input  logic [15:0] b_i,
   input  logic        cin_i,
   output logic [15:0] sum_o
);
   logic [15:0] g;
   logic [15:0] p;

   assign g = a_i & b_i;
   assign p = a_i ^ b_i;

   // Four 4-bit groups; group carries come from lookahead, bits ripple inside a group.
   always_comb begin
      logic [3:0]  cg;
      logic [15:0] c;
      logic        gk;
      logic        pk;
      cg    = '0;
      c     = '0;
      gk    = 1'b0;
      pk    = 1'b0;
      cg[0] = cin_i;
      for (int k = 0; k < 4; k++) begin
         gk = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
         pk = &p[4*k +: 4];
         if (k < 3) cg[k+1] = gk | (pk & cg[k]);
         c[4*k] = cg[k];
         for (int j = 1; j < 4; j++) c[4*k+j] = g[4*k+j-1] | (p[4*k+j-1] & c[4*k+j-1]);
      end
      sum_o = p ^ c;
   end
endmodule

module lc4_div_seq (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [15:0] dividend,
   input  logic [15:0] divisor,
   output logic        ready,
   output logic        valid_o,
   output logic [15:0] quotient,
   output logic [15:0] remainder
);
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]  state_q, state_d;
   logic [15:0] dvd_q, dvd_d;
   logic [15:0] dvs_q, dvs_d;
   logic [15:0] r_q, r_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [15:0] quo_q, quo_d;
   logic [15:0] rem_q, rem_d;

   logic [16:0] s;
   logic [15:0] nb;
   logic [15:0] t;
   logic        c15;
   logic        cout;
   logic        success;
   logic [15:0] qnext;

   // The stored remainder is always below the divisor, so its 17th bit is
   // always zero; the extra bit only appears in S after the shift.
   assign s  = {r_q, dvd_q[15]};
   assign nb = ~dvs_q;

   cla16 u_sub (
      .a_i   (s[15:0]),
      .b_i   (nb),
      .cin_i (1'b1),
      .sum_o (t)
   );

   assign c15     = s[15] ^ nb[15] ^ t[15];
   assign cout    = (s[15] & nb[15]) | ((s[15] ^ nb[15]) & c15);
   assign success = s[16] | cout;
   // The dividend register shifts out dividend bits and shifts in quotient bits.
   assign qnext   = {dvd_q[14:0], success};

   always_comb begin
      state_d = state_q;
      dvd_d   = dvd_q;
      dvs_d   = dvs_q;
      r_d     = r_q;
      cnt_d   = cnt_q;
      quo_d   = quo_q;
      rem_d   = rem_q;
      case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (start) begin
               dvd_d   = dividend;
               dvs_d   = divisor;
               r_d     = '0;
               cnt_d   = '0;
               state_d = RUN;
`ifdef LC4_DIV_ZERO_FAST_EN
               if (divisor == 16'd0) begin
                  state_d = DONE;
                  quo_d   = '0;
                  rem_d   = '0;
               end
`endif
            end
         end
         RUN: begin
            r_d   = success ? t : s[15:0];
            dvd_d = qnext;
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd15) begin
               state_d = DONE;
               // A zero divisor makes every trial succeed; force the ISA result instead.
               if (dvs_q == 16'd0) begin
                  quo_d = '0;
                  rem_d = '0;
               end else begin
                  quo_d = qnext;
                  rem_d = success ? t : s[15:0];
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         dvd_q   <= '0;
         dvs_q   <= '0;
         r_q     <= '0;
         cnt_q   <= '0;
         quo_q   <= '0;
         rem_q   <= '0;
      end else begin
         state_q <= state_d;
         dvd_q   <= dvd_d;
         dvs_q   <= dvs_d;
         r_q     <= r_d;
         cnt_q   <= cnt_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
      end
   end

   assign ready     = (state_q == IDLE) || (state_q == DONE);
   assign valid_o   = (state_q == DONE);
   assign quotient  = quo_q;
   assign remainder = rem_q;
endmodule

// File: tb/tb_lc4_div_seq.sv
// Directed bench for lc4_div_seq: hand-computed quotient/remainder, latency and handshake checks.
module tb_lc4_div_seq;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [15:0] dividend = '0;
   logic [15:0] divisor = '0;
   logic        ready;
   logic        valid_o;
   logic [15:0] quotient;
   logic [15:0] remainder;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

`ifdef LC4_DIV_ZERO_FAST_EN
   localparam int ZLAT = 0;
`else
   localparam int ZLAT = 16;
`endif

   lc4_div_seq dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .dividend  (dividend),
      .divisor   (divisor),
      .ready     (ready),
      .valid_o   (valid_o),
      .quotient  (quotient),
      .remainder (remainder)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_valid(output int at);
      int k = 0;
      while (!valid_o && k < 40) begin
         @(posedge clk);
         #1;
         k++;
      end
      check("valid_seen", {31'd0, valid_o}, 32'd1);
      at = cyc;
   endtask

   task automatic launch(input logic [15:0] a, input logic [15:0] b, output int acc);
      @(negedge clk);
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      check("ready_before_start", {31'd0, ready}, 32'd1);
      @(posedge clk);
      #1;
      start = 1'b0;
      acc   = cyc;
   endtask

   task automatic run_div(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] eq, input logic [15:0] er, input int elat);
      int acc;
      int at;
      launch(a, b, acc);
      wait_valid(at);
      check({tag, "_quot"}, {16'd0, quotient}, {16'd0, eq});
      check({tag, "_rem"}, {16'd0, remainder}, {16'd0, er});
      check({tag, "_lat"}, at - acc, elat);
   endtask

   initial begin
      int acc;
      int at;
      int at2;
      int vcount;

      repeat (2) @(posedge clk);
      #1;
      check("rst_ready", {31'd0, ready}, 32'd1);
      check("rst_valid", {31'd0, valid_o}, 32'd0);
      check("rst_quot", {16'd0, quotient}, 32'd0);
      check("rst_rem", {16'd0, remainder}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      run_div("nominal", 16'd100, 16'd7, 16'd14, 16'd2, 16);
      repeat (3) @(posedge clk);
      #1;
      check("hold_valid_low", {31'd0, valid_o}, 32'd0);
      check("hold_quot", {16'd0, quotient}, 32'd14);
      check("hold_rem", {16'd0, remainder}, 32'd2);

      run_div("max_by_1", 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 16);
      run_div("max_by_max", 16'hFFFF, 16'hFFFF, 16'h0001, 16'h0000, 16);
      run_div("small_by_big", 16'h0003, 16'h0010, 16'h0000, 16'h0003, 16);
      run_div("wide_partial", 16'hFFFE, 16'h8001, 16'h0001, 16'h7FFD, 16);
      run_div("div_zero", 16'h1234, 16'h0000, 16'h0000, 16'h0000, ZLAT);

      // Start pulse during RUN must be ignored.
      launch(16'd50, 16'd5, acc);
      repeat (4) @(posedge clk);
      @(negedge clk);
      dividend = 16'd9;
      divisor  = 16'd2;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      check("busy_ready_low", {31'd0, ready}, 32'd0);
      wait_valid(at);
      check("busy_quot", {16'd0, quotient}, 32'd10);
      check("busy_rem", {16'd0, remainder}, 32'd0);
      check("busy_lat", at - acc, 16);

      // Start held high through DONE: accepted there, held through the whole run.
      dividend = 16'd9;
      divisor  = 16'd2;
      start    = 1'b1;
      @(posedge clk);
      #1;
      check("b2b_accept", {31'd0, ready}, 32'd0);
      wait_valid(at2);
      start = 1'b0;
      check("b2b_quot", {16'd0, quotient}, 32'd4);
      check("b2b_rem", {16'd0, remainder}, 32'd1);
      check("b2b_period", at2 - at, 17);
      @(posedge clk);
      #1;
      check("b2b_idle_after", {31'd0, ready}, 32'd1);

      // Asynchronous reset between edges mid-run.
      launch(16'd100, 16'd7, acc);
      repeat (8) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("abort_ready", {31'd0, ready}, 32'd1);
      check("abort_valid", {31'd0, valid_o}, 32'd0);
      check("abort_quot", {16'd0, quotient}, 32'd0);
      check("abort_rem", {16'd0, remainder}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      rst_n  = 1'b1;
      vcount = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         if (valid_o) vcount++;
      end
      check("abort_no_valid", vcount, 0);
      run_div("after_abort", 16'd20, 16'd6, 16'd3, 16'd2, 16);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/lc4_div_seq.md
# lc4_div_seq

Iterative 16-bit unsigned divider for the LC4 ALU, serving the DIV and MOD opcodes. It produces one quotient bit per clock using restoring division. Each trial subtraction is done by one `cla16` instance wired as `a + ~b + 1`. The block sits beside the adder path, and its registered quotient and remainder feed the ALU result mux.

## Interface
- No parameters; the datapath is fixed at 16 bits.
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  **asynchronous, active-low reset.**
- `start`  in  1  request; sampled only while `ready`=1.
- `dividend`  in  16  unsigned dividend, sampled on the accepting edge.
- `divisor`  in  16  unsigned divisor, sampled on the accepting edge.
- `ready`  out  1  high when a request can be accepted (state IDLE or DONE).
- `valid_o`  out  1  one-cycle pulse marking a new result.
- `quotient`  out  16  last completed quotient.
- `remainder`  out  16  last completed remainder.

## Operation
- **State machine.** States are IDLE, RUN and DONE. Encode them as 2-bit localparams.
- **IDLE.** If `start`=1, latch the operands. Clear the partial remainder R (17 bits) and the step counter (4 bits), then go to RUN.
- **RUN.** Each edge does one iteration, working from the dividend MSB to the LSB:
  - S = {R[15:0], dividend bit}, 17 bits wide.
  - Trial T = S[15:0] + ~divisor + 1, computed through `cla16`.
  - The trial succeeds if S[16]=1, or if the carry-out of that addition is 1. The carry-out is rebuilt from bit-15 generate/propagate and the carry into bit 15 (S[15] ^ ~divisor[15] ^ T[15]).
  - On success, R gets T (16-bit wrap is correct) and the quotient bit is 1. Otherwise R gets S and the quotient bit is 0.
  - The counter increments each iteration. On the 16th iteration (counter=15), write the quotient and remainder output registers and go to DONE.
- **DONE.** Lasts exactly one cycle, with `valid_o`=1.
  - If `start`=1 during DONE, it is accepted exactly as from IDLE, and the next state is RUN.
  - Otherwise the next state is IDLE.
- **Busy.** `start` during RUN is ignored: no queueing, and the operands are not re-sampled.
- **Divide by zero.** Result is quotient=0, remainder=0, per the LC4 ISA convention. Timing depends on `LC4_DIV_ZERO_FAST_EN` (see Configuration).
- **Output hold.** `quotient` and `remainder` change only on a completion edge and hold until the next completion.
- **Reset values.** `rst_n`=0 forces state=IDLE, `ready`=1, `valid_o`=0, `quotient`=0, `remainder`=0, and clears R and the counter. This applies immediately, including mid-RUN. An aborted division produces no `valid_o`.

## Timing
- Accepting edge E0 is the rising edge with `ready`=1 and `start`=1.
- Iteration edges are E1 through E16. `valid_o`=1 in the cycle after E16, and the results are stable on that same cycle.
- Latency: 16 clocks from acceptance to result.
- `ready` is low for cycles E0+ through E15+ and high again in the DONE cycle.
- Back-to-back throughput: one result per 17 clocks when `start` is held high.
- `ready` and `valid_o` are decoded from registered state only, with no combinational path from the inputs.
- The combinational critical path per cycle is one `cla16` plus the 17-bit select mux.

## Configuration
- **Macro `LC4_DIV_ZERO_FAST_EN`.**
- **Defined:** a divisor of 0 on the accepting edge E0 jumps directly to DONE. It writes quotient=0 and remainder=0 at E0, and `valid_o`=1 in the cycle after E0 (latency 0 iterations).
- **Undefined:** there is no special path. The division runs the full 16 iterations and the datapath is masked so that E16 writes quotient=0 and remainder=0. Latency is then identical to the normal case.

## Test plan
- **Nominal.** Reset, then start with 100 / 7. Expect `valid_o` exactly 16 clocks after acceptance with quotient=14, remainder=2; the outputs hold afterwards.
- **Extremes.** 0xFFFF / 1 gives 0xFFFF, 0. 0xFFFF / 0xFFFF gives 1, 0. 0x0003 / 0x0010 gives 0, 3.
- **17-bit partial remainder.** 0xFFFE / 0x8001 gives quotient=1, remainder=0x7FFD.
- **Divide by zero.** 0x1234 / 0 gives 0, 0.
  - Macro defined: `valid_o` in the cycle after acceptance.
  - Macro undefined: `valid_o` 16 clocks after acceptance.
- **Handshake.**
  - Start 50 / 5, then pulse `start` with 9 / 2 at E5. Expect it ignored; the result is 10, 0.
  - Hold `start` high through DONE with new operands 9 / 2. Expect acceptance in DONE and the next result 4, 1 seventeen clocks later.
- **Reset mid-run.** Assert `rst_n`=0 asynchronously (between edges) at E8. Expect all outputs to clear immediately, `ready`=1, and no `valid_o`. A following 20 / 6 gives 3, 2.
